// File: rtl/full_adder_pkg.sv
// Shared helpers for the ripple-carry adder: signed-overflow detection from
// the last two carries of the chain.
package full_adder_pkg;

  // Signed overflow occurs when the carry into the MSB differs from the carry out.
  function automatic logic signed_ovf(input logic c_into_msb, input logic c_out);
    return c_into_msb ^ c_out;
  endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// One-bit full-adder cell: the basic sum/carry primitive of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_prop;

  assign w_prop = a ^ b;
  assign s      = w_prop ^ ci;
  assign co     = (a & b) | (ci & w_prop);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a combinational result and a one-cycle
// registered copy carrying valid and signed-overflow flags.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum_q,
  output logic             Cout_q,
  output logic             Ovf_q,
  output logic             out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum_p1;
  logic             r_cout_p1;
  logic             r_ovf_p1;
  logic             r_vld_p1;

  assign w_carry[0] = Cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    fa_cell u_cell (
      .a  (A[gi]),
      .b  (B[gi]),
      .ci (w_carry[gi]),
      .s  (w_sum[gi]),
      .co (w_carry[gi+1])
    );
  end

  // For WIDTH=1 the carry into the MSB is Cin itself (w_carry[0]).
  assign w_ovf = signed_ovf(w_carry[WIDTH-1], w_carry[WIDTH]);

  assign Sum  = w_sum;
  assign Cout = w_carry[WIDTH];

  // Stage p0 -> p1: capture the combinational result when qualified.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_p1  <= '0;
      r_cout_p1 <= 1'b0;
      r_ovf_p1  <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_sum_p1  <= w_sum;
        r_cout_p1 <= w_carry[WIDTH];
        r_ovf_p1  <= w_ovf;
      end
    end
  end

  assign Sum_q     = r_sum_p1;
  assign Cout_q    = r_cout_p1;
  assign Ovf_q     = r_ovf_p1;
  assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder at WIDTH=1, 4 and 8.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, v1 = 1'b0;
  logic       s1, co1, sq1, coq1, oq1, ov1;
  logic [3:0] a4 = '0, b4 = '0;
  logic       c4 = 1'b0, v4 = 1'b0;
  logic [3:0] s4, sq4;
  logic       co4, coq4, oq4, ov4;
  logic [7:0] a8 = '0, b8 = '0;
  logic       c8 = 1'b0, v8 = 1'b0;
  logic [7:0] s8, sq8;
  logic       co8, coq8, oq8, ov8;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .in_valid(v1),
    .Sum(s1), .Cout(co1), .Sum_q(sq1), .Cout_q(coq1), .Ovf_q(oq1), .out_valid(ov1)
  );
  full_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(c4), .in_valid(v4),
    .Sum(s4), .Cout(co4), .Sum_q(sq4), .Cout_q(coq4), .Ovf_q(oq4), .out_valid(ov4)
  );
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8), .in_valid(v8),
    .Sum(s8), .Cout(co8), .Sum_q(sq8), .Cout_q(coq8), .Ovf_q(oq8), .out_valid(ov8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] vec1 [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
  logic [1:0] exp1 [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

  initial begin
    logic [8:0] full;
    logic [7:0] m_sum;
    logic       m_cout, m_ovf, m_vld;

    // Reset state
    tick();
    tick();
    chk("rst_w1_vld", ov1, 0);
    chk("rst_w4_sumq", sq4, 0);
    chk("rst_w4_ovf", oq4, 0);
    chk("rst_w8_vld", ov8, 0);
    rst = 1'b0;
    tick();

    // WIDTH=1 truth table, combinational only
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = vec1[i];
      #1;
      chk($sformatf("w1_comb_%0d", i), {s1, co1}, exp1[i]);
    end

    // WIDTH=1 registered capture then hold
    a1 = 1; b1 = 1; c1 = 1; v1 = 1;
    tick();
    chk("w1_sumq", sq1, 1);
    chk("w1_coutq", coq1, 1);
    chk("w1_ovfq", oq1, 0);
    chk("w1_vld", ov1, 1);
    a1 = 0; b1 = 0; c1 = 0; v1 = 0;
    tick();
    chk("w1_vld_drop", ov1, 0);
    chk("w1_sumq_hold", sq1, 1);
    chk("w1_coutq_hold", coq1, 1);

    // WIDTH=4 boundaries
    a4 = 4'hF; b4 = 4'h1; c4 = 0; v4 = 1;
    #1;
    chk("w4_f1_sum", s4, 4'h0);
    chk("w4_f1_cout", co4, 1);
    tick();
    chk("w4_f1_ovfq", oq4, 0);
    chk("w4_f1_coutq", coq4, 1);
    a4 = 4'h7; b4 = 4'h1; c4 = 0;
    #1;
    chk("w4_71_sum", s4, 4'h8);
    chk("w4_71_cout", co4, 0);
    tick();
    chk("w4_71_ovfq", oq4, 1);
    chk("w4_71_sumq", sq4, 4'h8);
    a4 = 4'h8; b4 = 4'h8; c4 = 1;
    tick();
    chk("w4_881_sumq", sq4, 4'h1);
    chk("w4_881_coutq", coq4, 1);
    chk("w4_881_ovfq", oq4, 1);
    chk("w4_881_vld", ov4, 1);

    // Reset dominates in_valid; combinational path unaffected
    a4 = 4'hF; b4 = 4'hF; c4 = 0; v4 = 1; rst = 1;
    #1;
    chk("w4_rst_sum", s4, 4'hE);
    chk("w4_rst_cout", co4, 1);
    tick();
    chk("w4_rst_sumq", sq4, 0);
    chk("w4_rst_coutq", coq4, 0);
    chk("w4_rst_ovfq", oq4, 0);
    chk("w4_rst_vld", ov4, 0);
    chk("w4_rst_sum2", s4, 4'hE);
    rst = 0; v4 = 0;
    tick();

    // WIDTH=8 stream with a reference model
    m_sum = '0; m_cout = 0; m_ovf = 0; m_vld = 0;
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      v8 = ($urandom_range(0, 3) != 0);
      if (i < 4) begin
        a8 = (i == 0) ? 8'hFF : (i == 1) ? 8'h7F : (i == 2) ? 8'h80 : 8'h00;
        b8 = (i == 0) ? 8'h00 : (i == 1) ? 8'h00 : (i == 2) ? 8'h80 : 8'h00;
        c8 = (i != 3);
        v8 = 1;
      end
      #1;
      full = {1'b0, a8} + {1'b0, b8} + {8'b0, c8};
      chk("w8_comb", {co8, s8}, full);
      if (v8) begin
        m_sum  = full[7:0];
        m_cout = full[8];
        m_ovf  = (a8[7] == b8[7]) && (full[7] != a8[7]);
      end
      m_vld = v8;
      tick();
      chk("w8_vld", ov8, m_vld);
      chk("w8_q", {oq8, coq8, sq8}, {m_ovf, m_cout, m_sum});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
